// File: rtl/counter_ctrl.sv
// counter_ctrl: start/pause/clear/terminal-count sequencer around a WIDTH-bit up-counter.
// Optional feature macro PRESCALE_EN divides the count tick by prescale+1.
module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                mode,
  input  logic [WIDTH-1:0]    period,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]    q,
  output logic                busy,
  output logic                done,
  output logic                tc_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             load;
  logic             tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    mode_d  = mode_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    load    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start && (period != '0)) begin
            state_d = RUN;
            cnt_d   = '0;
            done_d  = 1'b0;
            per_d   = period;
            mode_d  = mode;
            load    = 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (cnt_q == per_q) begin
              tc_d = 1'b1;
              if (mode_q) begin
                cnt_d = '0;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        PAUSE: begin
          if (start && !stop) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PRESCALE_EN
  localparam logic [PS_WIDTH-1:0] PS_ONE = PS_WIDTH'(1);

  logic [PS_WIDTH-1:0] ps_q, ps_d;
  logic [PS_WIDTH-1:0] pre_q, pre_d;

  assign tick = (ps_q == pre_q);

  // Divider only advances on un-stopped RUN cycles, so PAUSE freezes it.
  always_comb begin
    ps_d  = ps_q;
    pre_d = pre_q;
    if (clear) begin
      ps_d = '0;
    end else if (load) begin
      ps_d  = '0;
      pre_d = prescale;
    end else if ((state_q == RUN) && !stop) begin
      ps_d = tick ? '0 : ps_q + PS_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_q  <= '0;
      pre_q <= '0;
    end else begin
      ps_q  <= ps_d;
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^{prescale, load};
  assign tick = 1'b1;
`endif

  assign q        = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc_pulse = tc_q;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencing controller for the team's free-running up-counter datapath: owns an internal WIDTH-bit count register and a small FSM that starts, pauses, resumes, clears and terminates counting against a programmable period. Supports one-shot and periodic (auto-reload) modes and emits a terminal-count pulse plus busy/done status. Sits between a host or test sequencer and any logic needing timed events.

Parameters:
WIDTH, 8, width of count register q and period input
PS_WIDTH, 4, width of prescale input (used only with PRESCALE_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous reset, active-low (0 = reset asserted)
start  input  1  start from IDLE/DONE, resume from PAUSE
stop  input  1  pause counting while in RUN
clear  input  1  synchronous abort to IDLE
mode  input  1  0 = one-shot, 1 = periodic; latched at start
period  input  WIDTH  terminal count value; latched at start
prescale  input  PS_WIDTH  tick divider; latched at start; ignored without PRESCALE_EN
q  output  WIDTH  current count, registered
busy  output  1  high in RUN and PAUSE
done  output  1  sticky one-shot completion flag
tc_pulse  output  1  one-cycle pulse on each terminal count

Behaviour:
- Reset low (async): state IDLE, q=0, busy=0, done=0, tc_pulse=0, latched period/mode/prescale=0. Outputs hold these values while reset is low.
- States: IDLE, RUN, PAUSE, DONE. busy = (RUN or PAUSE); all outputs registered.
- Priority each edge: clear > stop > start.
- clear (any state): next state IDLE, q=0, done=0, busy=0, tc_pulse=0.
- IDLE/DONE + start, period != 0: latch period/mode/prescale, q=0, done=0, go RUN. Ignore stop in these states.
- IDLE/DONE + start, period == 0: ignored, no state or output change.
- RUN: q increments by 1 on each tick. Without PRESCALE_EN, tick = every cycle.
- RUN, tick with q == period_r:
  - periodic: q wraps to 0, stay RUN, tc_pulse=1 for the next cycle.
  - one-shot: q holds at period_r, go DONE, busy=0, done=1, tc_pulse=1 for one cycle.
- RUN + stop: go PAUSE, q holds, busy stays 1. start in RUN is ignored (no restart).
- PAUSE + start (stop low): back to RUN with no reload; q continues from its held value. stop in PAUSE has no effect. start and stop together in PAUSE: stay PAUSE.
- done is sticky. It clears only on start from DONE or on clear.
- Latency: start sampled at edge N gives q=0 and busy=1 after N, q=k after N+k, q=P after N+P. At N+P+1, tc_pulse=1 for one cycle and q=0 (periodic) or done=1 (one-shot).
- mode/period/prescale changes after start have no effect until the next start from IDLE/DONE.
- q never exceeds period_r. period = 2^WIDTH-1 is legal, with no overflow beyond WIDTH bits.
- Reset mid-RUN: immediate return to reset values. Counting resumes only on a new start.

Optional Feature:
PRESCALE_EN
- Defined: internal PS_WIDTH prescale counter. tick asserts once every prescale_r+1 cycles in RUN.
  - Prescale counter zeroes on start from IDLE/DONE, on clear and on reset. It holds in PAUSE.
  - Terminal-count latency becomes (P+1)*(prescale_r+1) cycles.
- Undefined: tick = 1 every RUN cycle; prescale port is present but unused; no prescale counter is synthesized.

Test Plan:
- Reset low 20 ns then high; start=1 for one cycle with period=5, mode=0 -> q steps 0..5 on consecutive edges; at the next edge tc_pulse=1 for one cycle, done=1, busy=0, q holds 5.
- period=3, mode=1 -> q sequence 0,1,2,3,0,1,2,3,... with a tc_pulse every 4 cycles; busy stays 1; done stays 0.
- period=10; stop at q=4, hold 5 cycles, then start -> q stays 4 during PAUSE; resumes 5,6,...,10; tc_pulse fires 7 cycles after resume.
- Simultaneous events: clear+start+stop in RUN -> IDLE, q=0; start with period=0 in IDLE -> no change; start+stop in IDLE with period=2 -> RUN.
- Reset low asserted asynchronously mid-RUN at q=7 (no clock edge) -> q=0, busy=0, done=0 immediately; stays IDLE after release until start.
- PRESCALE_EN, prescale=2, period=2, one-shot -> q increments every 3 cycles; done=1 at cycle 9 after start.
